// File: rtl/keypad_sample_entry_pkg.sv
// Shared definitions for the keypad sample-entry block: FSM states, keypad legend,
// and the rule that places a 16-bit sample into the wider FFT input word.
package keypad_sample_entry_pkg;

    typedef enum logic [0:0] {
        StEntry,
        StStream
    } state_e;

    // Width of one entered sample (four hex digits).
    localparam int unsigned SampleW = 16;
    // Samples sit in x_out[19:4]; the low nibble is zero.
    localparam int unsigned XShift  = 4;

    // Keypad legend indexed by 4*row + col, rows top to bottom, columns left to right.
    localparam logic [3:0] KeyMap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Number of sign-replicated bits above the sample in a bw-wide output word.
    function automatic int unsigned sext_width(input int unsigned bw);
        return bw - SampleW - XShift;
    endfunction

    function automatic logic is_onehot(input logic [15:0] m);
        return (m != '0) && ((m & (m - 16'd1)) == '0);
    endfunction

    // Legend of the (single) key set in a key map.
    function automatic logic [3:0] key_code(input logic [15:0] m);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) c = KeyMap[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/keypad_sample_entry_scan.sv
// Keypad scanner: drives one row low at a time, samples the columns at the end of each
// row slot, assembles a 16-bit sweep, debounces whole sweeps and emits one press event
// per clean single-key press.
module keypad_scan
    import keypad_sample_entry_pkg::*;
#(
    parameter int unsigned SCAN_CYC  = 50_000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_col_i,
    output logic [3:0] key_row_o,
    output logic       evt_o,
    output logic [3:0] code_o
);

    localparam int unsigned CntW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int unsigned DebW = $clog2(DEB_SCANS + 1);

    logic [CntW-1:0] cnt_q;
    logic [1:0]      row_q;
    logic [1:0]      row_nxt;
    logic [3:0]      key_row_q;
    logic [11:0]     raw_q;      // rows 0..2 of the sweep in progress
    logic [15:0]     prev_q;     // previous full sweep
    logic [15:0]     stable_q;   // debounced key map
    logic [DebW-1:0] deb_q;      // run length of identical sweeps, saturating
    logic            evt_q;
    logic [3:0]      code_q;

    logic            slot_end;
    logic [15:0]     sweep;
    logic [DebW-1:0] deb_d;
    logic [15:0]     stable_d;

    // Slot timing, current sweep (row 3 taken live) and debounce next-state
    always_comb begin
        slot_end = (cnt_q == CntW'(SCAN_CYC - 1));
        row_nxt  = row_q + 2'd1;
        sweep    = {~key_col_i, raw_q};
        if (sweep == prev_q) begin
            deb_d = (deb_q == DebW'(DEB_SCANS)) ? deb_q : deb_q + 1'b1;
        end else begin
            deb_d = DebW'(1);
        end
        stable_d = (deb_d == DebW'(DEB_SCANS)) ? sweep : stable_q;
    end

    // Row drive, column sampling, and per-sweep debounce / press-event update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            row_q     <= 2'd0;
            key_row_q <= 4'b1110;
            raw_q     <= '0;
            prev_q    <= '0;
            stable_q  <= '0;
            deb_q     <= '0;
            evt_q     <= 1'b0;
            code_q    <= 4'h0;
        end else begin
            evt_q <= 1'b0;
            if (slot_end) begin
                cnt_q     <= '0;
                row_q     <= row_nxt;
                key_row_q <= ~(4'b0001 << row_nxt);
                unique case (row_q)
                    2'd0: raw_q[3:0]  <= ~key_col_i;
                    2'd1: raw_q[7:4]  <= ~key_col_i;
                    2'd2: raw_q[11:8] <= ~key_col_i;
                    2'd3: begin
                        prev_q   <= sweep;
                        deb_q    <= deb_d;
                        stable_q <= stable_d;
                        // Only a clean 0 -> single-key transition is a press
                        evt_q    <= (stable_q == '0) && is_onehot(stable_d);
                        code_q   <= key_code(stable_d);
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign key_row_o = key_row_q;
    assign evt_o     = evt_q;
    assign code_o    = code_q;

endmodule

// File: rtl/keypad_sample_entry.sv
// Keypad sample entry: collects four hex digits per signed sample, buffers a frame of N
// samples, then streams the frame to the FFT input on N back-to-back valid cycles.
module keypad_sample_entry
    import keypad_sample_entry_pkg::*;
#(
    parameter int unsigned bit_width = 32,
    parameter int unsigned N         = 16,
    parameter int unsigned SIZE      = 4,
    parameter int unsigned SCAN_CYC  = 50_000,
    parameter int unsigned DEB_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           key_col,
    output logic [3:0]           key_row,
    output logic                 en_out,
    output logic [bit_width-1:0] x_out,
    output logic [bit_width-1:0] y_out,
    output logic [15:0]          entry_digits,
    output logic [1:0]           entry_cnt,
    output logic [SIZE-1:0]      sample_idx,
    output logic                 busy
);

    localparam int unsigned ExtW = sext_width(bit_width);

    logic                 evt;
    logic [3:0]           code;

    state_e               state_q;
    logic [15:0]          entry_digits_q;
    logic [1:0]           entry_cnt_q;
    logic [SIZE-1:0]      sample_idx_q;
    logic [SIZE-1:0]      rd_ptr_q;
    logic                 en_out_q;
    logic                 busy_q;
    logic [bit_width-1:0] x_out_q;
    logic [SampleW-1:0]   smp_buf_q [N];

    logic                 commit;
    logic [SampleW-1:0]   new_sample;
    logic [SampleW-1:0]   rd_sample;

    keypad_scan #(
        .SCAN_CYC  (SCAN_CYC),
        .DEB_SCANS (DEB_SCANS)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_col_i (key_col),
        .key_row_o (key_row),
        .evt_o     (evt),
        .code_o    (code)
    );

    assign commit     = (state_q == StEntry) && evt && (entry_cnt_q == 2'd3);
    assign new_sample = {entry_digits_q[11:0], code};
    assign rd_sample  = smp_buf_q[rd_ptr_q];

    // Sample buffer; not reset, stale contents are never read before being rewritten
    always_ff @(posedge clk) begin
        if (commit) smp_buf_q[sample_idx_q] <= new_sample;
    end

    // Entry / stream FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StEntry;
            entry_digits_q <= '0;
            entry_cnt_q    <= '0;
            sample_idx_q   <= '0;
            rd_ptr_q       <= '0;
            en_out_q       <= 1'b0;
            busy_q         <= 1'b0;
            x_out_q        <= '0;
        end else begin
            unique case (state_q)
                StEntry: begin
                    en_out_q <= 1'b0;
                    busy_q   <= 1'b0;
                    x_out_q  <= '0;
                    if (evt) begin
                        if (entry_cnt_q == 2'd3) begin
                            entry_digits_q <= '0;
                            entry_cnt_q    <= '0;
                            if (sample_idx_q == SIZE'(N - 1)) begin
                                sample_idx_q <= '0;
                                rd_ptr_q     <= '0;
                                state_q      <= StStream;
                            end else begin
                                sample_idx_q <= sample_idx_q + 1'b1;
                            end
                        end else begin
                            entry_digits_q <= new_sample;
                            entry_cnt_q    <= entry_cnt_q + 2'd1;
                        end
                    end
                end
                StStream: begin
                    // Key events are dropped here; the scanner keeps running
                    en_out_q <= 1'b1;
                    busy_q   <= 1'b1;
                    x_out_q  <= {{ExtW{rd_sample[SampleW-1]}}, rd_sample, {XShift{1'b0}}};
                    if (rd_ptr_q == SIZE'(N - 1)) begin
                        state_q <= StEntry;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign en_out       = en_out_q;
    assign busy         = busy_q;
    assign x_out        = x_out_q;
    assign y_out        = '0;
    assign entry_digits = entry_digits_q;
    assign entry_cnt    = entry_cnt_q;
    assign sample_idx   = sample_idx_q;

endmodule

// File: tb/tb_keypad_sample_entry.sv
// Scoreboard bench for keypad_sample_entry: a keypad model drives the columns, a
// sweep-level reference model predicts entry updates and streamed samples, and a
// monitor compares whatever the DUT presents against the predictions.
module tb_keypad_sample_entry;

    localparam int unsigned ScanCyc  = 4;
    localparam int unsigned DebScans = 2;
    localparam int unsigned NSmp     = 16;
    localparam int unsigned SweepCyc = 4 * ScanCyc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic        en_out;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [15:0] entry_digits;
    logic [1:0]  entry_cnt;
    logic [3:0]  sample_idx;
    logic        busy;

    logic [15:0] held_map = 16'h0;  // keys physically held, bit 4*row+col
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  c;
        logic [3:0]  i;
    } tup_t;

    // Reference model state
    string       key_str = "123A456B789CE0FD";
    logic [15:0] m_hist[$];
    logic [15:0] m_stable;
    int          m_digits[$];
    int          m_frame[$];
    int          m_frames_done;
    int unsigned m_stream_end;
    tup_t        exp_tup[$];
    logic [31:0] exp_x[$];

    keypad_sample_entry #(
        .bit_width (32),
        .N         (NSmp),
        .SIZE      (4),
        .SCAN_CYC  (ScanCyc),
        .DEB_SCANS (DebScans)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_col      (key_col),
        .key_row      (key_row),
        .en_out       (en_out),
        .x_out        (x_out),
        .y_out        (y_out),
        .entry_digits (entry_digits),
        .entry_cnt    (entry_cnt),
        .sample_idx   (sample_idx),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive keypad: a held key shorts its column low while its row is driven low
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!key_row[r]) key_col = key_col & ~held_map[4*r +: 4];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int hexval(input byte ch);
        if (ch >= "0" && ch <= "9") return int'(ch - "0");
        return int'(ch - "A") + 10;
    endfunction

    function automatic int key_of(input int digit);
        for (int i = 0; i < 16; i++) begin
            if (hexval(key_str[i]) == digit) return i;
        end
        return 0;
    endfunction

    function automatic logic [15:0] kbit(input int digit);
        logic [15:0] m;
        m = 16'h1 << key_of(digit);
        return m;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_digits.delete();
        m_frame.delete();
        m_stable     = '0;
        m_stream_end = 0;
    endtask

    // Accepted key: append a digit; four digits make a sample, N samples make a frame
    task automatic model_accept(input int digit);
        tup_t t;
        int   v;
        if (cyc < m_stream_end) return;
        m_digits.push_back(digit);
        if (m_digits.size() == 4) begin
            v = ((m_digits[0] * 16 + m_digits[1]) * 16 + m_digits[2]) * 16 + m_digits[3];
            m_digits.delete();
            m_frame.push_back(v);
            if (m_frame.size() == NSmp) begin
                foreach (m_frame[k]) begin
                    int s;
                    s = (m_frame[k] >= 32768) ? m_frame[k] - 65536 : m_frame[k];
                    exp_x.push_back(32'(s * 16));
                end
                m_frame.delete();
                m_frames_done++;
                m_stream_end = cyc + 20;
            end
        end
        v = 0;
        foreach (m_digits[k]) v = v * 16 + m_digits[k];
        t.d = 16'(v);
        t.c = 2'(m_digits.size());
        t.i = 4'(m_frame.size());
        exp_tup.push_back(t);
    endtask

    // One full sweep seen: debounce over the last DebScans sweeps, detect a clean press
    task automatic model_sweep(input logic [15:0] m);
        logic [15:0] ns;
        bit          same;
        ns   = m_stable;
        same = 1'b1;
        m_hist.push_back(m);
        if (m_hist.size() > DebScans) void'(m_hist.pop_front());
        if (m_hist.size() == DebScans) begin
            foreach (m_hist[k]) if (m_hist[k] != m) same = 1'b0;
            if (same) ns = m;
        end
        if (m_stable == '0 && $countones(ns) == 1) begin
            for (int i = 0; i < 16; i++) if (ns[i]) model_accept(hexval(key_str[i]));
        end
        m_stable = ns;
    endtask

    // Hold a key map for exactly one scanner sweep (called on a sweep-aligned negedge)
    task automatic sweep(input logic [15:0] m);
        held_map = m;
        repeat (SweepCyc) @(negedge clk);
        model_sweep(m);
    endtask

    task automatic press(input int digit, input int hold, input int rel);
        repeat (hold) sweep(kbit(digit));
        repeat (rel) sweep(16'h0);
    endtask

    task automatic check_drained(input string name);
        check({name, "_entry_pending"}, 64'(exp_tup.size()), 64'd0);
        check({name, "_stream_pending"}, 64'(exp_x.size()), 64'd0);
    endtask

    // Assert reset for a few cycles, check reset values, release on a negedge
    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        held_map = '0;
        model_reset();
        exp_tup.delete();
        exp_x.delete();
        repeat (3) @(negedge clk);
        check("rst_key_row", 64'(key_row), 64'h0E);
        check("rst_en_out", 64'(en_out), 64'd0);
        check("rst_x_out", 64'(x_out), 64'd0);
        check("rst_y_out", 64'(y_out), 64'd0);
        check("rst_entry_digits", 64'(entry_digits), 64'd0);
        check("rst_entry_cnt", 64'(entry_cnt), 64'd0);
        check("rst_sample_idx", 64'(sample_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
    endtask

    // Monitor: entry-state changes and stream beats are popped from the scoreboard
    initial begin
        tup_t last;
        tup_t cur;
        int   run;
        last = '0;
        run  = 0;
        forever begin
            @(negedge clk);
            cur = {entry_digits, entry_cnt, sample_idx};
            if (!rst_n) begin
                last = cur;
                run  = 0;
            end else begin
                if (cur != last) begin
                    if (exp_tup.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_entry: got %0h, expected no change", cur);
                    end else begin
                        tup_t e;
                        e = exp_tup.pop_front();
                        check("entry_state", 64'(cur), 64'(e));
                    end
                    last = cur;
                end
                if (en_out) begin
                    run++;
                    if (exp_x.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_stream: got x_out %0h, expected no beat", x_out);
                    end else begin
                        logic [31:0] ex;
                        ex = exp_x.pop_front();
                        check("stream_x", 64'(x_out), 64'(ex));
                    end
                    check("stream_y", 64'(y_out), 64'd0);
                    check("stream_busy", 64'(busy), 64'd1);
                end else begin
                    if (run != 0) check("stream_len", 64'(run), 64'(NSmp));
                    run = 0;
                    if (busy) check("busy_idle", 64'(busy), 64'd0);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        logic [3:0] er;
        m_frames_done = 0;
        model_reset();

        // Reset, then reset again in the middle of a row slot
        do_reset();
        repeat (6) @(negedge clk);
        do_reset();
        // Row scan advances every ScanCyc cycles from row 0
        held_map = '0;
        for (int i = 0; i < SweepCyc; i++) begin
            er = ~(4'h1 << (i / ScanCyc));
            check("row_scan", 64'(key_row), 64'(er));
            @(negedge clk);
        end
        model_sweep(16'h0);
        sweep(16'h0);

        // Key 5 held long: one event, no auto-repeat
        press(5, 13, 2);
        check_drained("key5");
        check("key5_digits", 64'(entry_digits), 64'h0005);
        check("key5_cnt", 64'(entry_cnt), 64'd1);

        // Chatter on key 0, then a stable press
        repeat (3) begin
            sweep(kbit(0));
            sweep(16'h0);
        end
        check("chatter_quiet", 64'(entry_cnt), 64'd1);
        press(0, 2, 2);
        check("chatter_cnt", 64'(entry_cnt), 64'd2);

        // Two keys together, then one released, then a fresh single press
        repeat (3) sweep(kbit(2) | kbit(6));
        repeat (3) sweep(kbit(2));
        repeat (2) sweep(16'h0);
        check("multi_quiet", 64'(entry_cnt), 64'd2);
        press(6, 3, 2);
        check_drained("multi");
        check("multi_digits", 64'(entry_digits), 64'h0506);

        // Reset mid-entry clears the partial sample
        do_reset();
        repeat (2) sweep(16'h0);

        // Frame 1: sample k = 0x0100*k; last key held through the stream with a second key
        for (int k = 0; k < NSmp; k++) begin
            press(0, 3, 2);
            press(k, 3, 2);
            press(0, 3, 2);
            if (k == NSmp - 1) begin
                repeat (3) sweep(kbit(0));
                repeat (3) sweep(kbit(0) | kbit(7));
                repeat (3) sweep(16'h0);
            end else begin
                press(0, 3, 2);
            end
        end
        check_drained("frame1");
        check("frame1_cnt", 64'(entry_cnt), 64'd0);
        check("frame1_idx", 64'(sample_idx), 64'd0);

        // Frame 2: signed extremes first, then random digits with random timing
        press(8, 3, 2); press(0, 3, 2); press(0, 3, 2); press(0, 3, 2);
        press(7, 3, 2); press(15, 3, 2); press(15, 3, 2); press(15, 3, 2);
        guard = 0;
        while (m_frames_done < 2 && guard < 400) begin
            press(int'($urandom_range(0, 15)), int'($urandom_range(2, 4)),
                  int'($urandom_range(1, 3)));
            guard++;
        end
        check("frame2_complete", 64'(m_frames_done), 64'd2);
        repeat (3) sweep(16'h0);
        check_drained("frame2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
